nmr_vote_ctrl: RTL and testbench

Parametrised N-modular-redundancy voter and recovery controller for the redundant RISC-V cores. Generalises the fixed triple voter/lockstep pair to LANES cores of configurable word width. Adds per-lane fault counting, permanent lane quarantine and a hold/resync handshake toward the core reset and rollback logic. Sits between the core outputs (PC, ALUResult, RD2, MemWrite) and the memory/recovery path.

---
 rtl/nmr_pkg.sv | 13 +
 rtl/nmr_majority.sv | 57 +++++
 rtl/nmr_vote_ctrl.sv | 154 +++++++++++++++
 tb/tb_nmr_vote_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nmr_pkg.sv
// Shared state encoding for the N-modular-redundancy voter and its controller.
package nmr_pkg;

  localparam int VOTE_STATE_W = 2;

  typedef enum logic [VOTE_STATE_W-1:0] {
    ST_RUN    = 2'd0,
    ST_HOLD   = 2'd1,
    ST_RESYNC = 2'd2,
    ST_FAIL   = 2'd3
  } vote_state_e;

endpackage

// File: rtl/nmr_majority.sv
// Combinational majority finder over LANES compare keys, restricted to the active lanes.
module nmr_majority #(
  parameter int LANES = 3,
  parameter int KEY_W = 33,
  parameter int IDX_W = $clog2(LANES)
) (
  input  logic [LANES*KEY_W-1:0] keys,
  input  logic [LANES-1:0]       active,
  output logic [IDX_W-1:0]       win_idx,
  output logic                   majority_ok,
  output logic [LANES-1:0]       differ
);

  localparam int AC_W = $clog2(LANES + 1);

  logic [AC_W-1:0]  active_cnt;
  logic [AC_W-1:0]  acc;
  logic [AC_W-1:0]  agree [LANES];
  logic [KEY_W-1:0] win_key;

  always_comb begin
    active_cnt = '0;
    for (int i = 0; i < LANES; i++)
      active_cnt = active_cnt + AC_W'(active[i]);
  end

  always_comb begin
    acc = '0;
    for (int i = 0; i < LANES; i++) begin
      acc = '0;
      for (int j = 0; j < LANES; j++)
        if (active[j] && (keys[j*KEY_W +: KEY_W] == keys[i*KEY_W +: KEY_W]))
          acc = acc + AC_W'(1);
      agree[i] = acc;
    end
  end

  // Scan from the top down so the lowest qualifying lane is the one left standing.
  always_comb begin
    majority_ok = 1'b0;
    win_idx     = '0;
    win_key     = keys[KEY_W-1:0];
    for (int i = LANES - 1; i >= 0; i--)
      if (active[i] && (agree[i] > (active_cnt >> 1))) begin
        majority_ok = 1'b1;
        win_idx     = IDX_W'(i);
        win_key     = keys[i*KEY_W +: KEY_W];
      end
  end

  always_comb begin
    differ = '0;
    for (int i = 0; i < LANES; i++)
      differ[i] = majority_ok && active[i] && (keys[i*KEY_W +: KEY_W] != win_key);
  end

endmodule

// File: rtl/nmr_vote_ctrl.sv
// N-modular-redundancy voter with per-lane fault counting, sticky quarantine and a
// hold/resync handshake toward the core reset and rollback logic.
//
//   state  | meaning
//   RUN    | voting every cycle, cores running
//   HOLD   | cores stalled for HOLD_CYCLES after a lane mismatch
//   RESYNC | cores stalled, rollback requested until resync_ack
//   FAIL   | no majority; cores stalled until reset
module nmr_vote_ctrl
  import nmr_pkg::*;
#(
  parameter int LANES        = 3,
  parameter int WIDTH        = 32,
  parameter int FAULT_THRESH = 2,
  parameter int CNT_W        = 3,
  parameter int HOLD_CYCLES  = 2
) (
  input  logic                    clk,
  input  logic                    rst_in,
  input  logic [LANES*WIDTH-1:0]  lane_word,
  input  logic [LANES-1:0]        lane_we,
  input  logic                    resync_ack,
  output logic [WIDTH-1:0]        voted_word,
  output logic                    voted_we,
  output logic                    core_hold,
  output logic                    resync_req,
  output logic [LANES-1:0]        lane_mismatch,
  output logic [LANES-1:0]        lane_quarantine,
  output logic                    fatal,
  output logic [VOTE_STATE_W-1:0] vote_state
);

  localparam int KEY_W = WIDTH + 1;
  localparam int IDX_W = $clog2(LANES);
  localparam int HC_W  = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  vote_state_e      state_q, state_d;
  logic [HC_W-1:0]  hold_cnt_q, hold_cnt_d;
  logic [CNT_W-1:0] cnt_q [LANES];
  logic [CNT_W-1:0] cnt_d [LANES];
  logic [LANES-1:0] quar_q, quar_d;
  logic [LANES-1:0] mism_q, mism_d;
  logic             core_hold_q, core_hold_d;
  logic             resync_req_q, resync_req_d;
  logic             fatal_q, fatal_d;

  logic [LANES*KEY_W-1:0] keys;
  logic [IDX_W-1:0]       win_idx;
  logic                   majority_ok;
  logic [LANES-1:0]       differ;
  logic                   win_we;

  always_comb begin
    keys = '0;
    for (int i = 0; i < LANES; i++)
      keys[i*KEY_W +: KEY_W] = {lane_we[i], lane_word[i*WIDTH +: WIDTH]};
  end

  nmr_majority #(
    .LANES (LANES),
    .KEY_W (KEY_W),
    .IDX_W (IDX_W)
  ) u_majority (
    .keys        (keys),
    .active      (~quar_q),
    .win_idx     (win_idx),
    .majority_ok (majority_ok),
    .differ      (differ)
  );

  // Without a majority the index stays 0, which is exactly the lane-0 fallback word.
  always_comb begin
    voted_word = lane_word[WIDTH-1:0];
    win_we     = lane_we[0];
    for (int i = 0; i < LANES; i++)
      if (win_idx == IDX_W'(i)) begin
        voted_word = lane_word[i*WIDTH +: WIDTH];
        win_we     = lane_we[i];
      end
  end

  assign voted_we = majority_ok && win_we && !core_hold_q;

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    cnt_d      = cnt_q;
    quar_d     = quar_q;
    mism_d     = mism_q;
    case (state_q)
      ST_RUN: begin
        mism_d = differ;
        if (!majority_ok) begin
          state_d = ST_FAIL;
        end else if (|differ) begin
          state_d    = ST_HOLD;
          hold_cnt_d = HC_W'(HOLD_CYCLES - 1);
          for (int i = 0; i < LANES; i++)
            if (differ[i]) begin
              if (cnt_q[i] != {CNT_W{1'b1}})
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
              if (cnt_d[i] >= CNT_W'(FAULT_THRESH))
                quar_d[i] = 1'b1;
            end
        end
      end
      ST_HOLD: begin
        if (hold_cnt_q == '0)
          state_d = ST_RESYNC;
        else
          hold_cnt_d = hold_cnt_q - HC_W'(1);
      end
      ST_RESYNC: begin
        if (resync_ack)
          state_d = ST_RUN;
      end
      default: state_d = ST_FAIL;
    endcase
    core_hold_d  = (state_d != ST_RUN);
    resync_req_d = (state_d == ST_RESYNC);
    fatal_d      = (state_d == ST_FAIL);
  end

  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      state_q      <= ST_RUN;
      hold_cnt_q   <= '0;
      quar_q       <= '0;
      mism_q       <= '0;
      core_hold_q  <= 1'b0;
      resync_req_q <= 1'b0;
      fatal_q      <= 1'b0;
      for (int i = 0; i < LANES; i++)
        cnt_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      hold_cnt_q   <= hold_cnt_d;
      quar_q       <= quar_d;
      mism_q       <= mism_d;
      core_hold_q  <= core_hold_d;
      resync_req_q <= resync_req_d;
      fatal_q      <= fatal_d;
      cnt_q        <= cnt_d;
    end
  end

  assign core_hold       = core_hold_q;
  assign resync_req      = resync_req_q;
  assign lane_mismatch   = mism_q;
  assign lane_quarantine = quar_q;
  assign fatal           = fatal_q;
  assign vote_state      = state_q;

endmodule

// File: tb/tb_nmr_vote_ctrl.sv
// Bench for nmr_vote_ctrl: a 3-lane and a 5-lane instance checked every cycle against
// a behavioural model, plus directed literal checks.
`timescale 1ns/1ps
module tb_nmr_vote_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_a, rst_b;
  logic [95:0]  word_a;
  logic [2:0]   we_a;
  logic         ack_a;
  logic [159:0] word_b;
  logic [4:0]   we_b;
  logic         ack_b;

  logic [31:0] vw_a, vw_b;
  logic        vwe_a, vwe_b, hold_a, hold_b, req_a, req_b, fatal_a, fatal_b;
  logic [2:0]  mm_a, q_a;
  logic [4:0]  mm_b, q_b;
  logic [1:0]  st_a, st_b;

  nmr_vote_ctrl #(.LANES(3), .WIDTH(32), .FAULT_THRESH(2), .CNT_W(3), .HOLD_CYCLES(2)) dut_a (
    .clk(clk), .rst_in(rst_a), .lane_word(word_a), .lane_we(we_a), .resync_ack(ack_a),
    .voted_word(vw_a), .voted_we(vwe_a), .core_hold(hold_a), .resync_req(req_a),
    .lane_mismatch(mm_a), .lane_quarantine(q_a), .fatal(fatal_a), .vote_state(st_a));

  nmr_vote_ctrl #(.LANES(5), .WIDTH(32), .FAULT_THRESH(2), .CNT_W(3), .HOLD_CYCLES(2)) dut_b (
    .clk(clk), .rst_in(rst_b), .lane_word(word_b), .lane_we(we_b), .resync_ack(ack_b),
    .voted_word(vw_b), .voted_we(vwe_b), .core_hold(hold_b), .resync_req(req_b),
    .lane_mismatch(mm_b), .lane_quarantine(q_b), .fatal(fatal_b), .vote_state(st_b));

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: mode 0 run, 1 hold, 2 resync, 3 fail
  int m_mode [2];
  int m_hold [2];
  int m_cnt  [2][5];
  bit m_q    [2][5];
  bit m_mm   [2][5];

  function automatic int nl(input int d);
    return (d == 0) ? 3 : 5;
  endfunction

  function automatic logic [32:0] key(input int d, input int i);
    if (d == 0) return {we_a[i], word_a[i*32 +: 32]};
    return {we_b[i], word_b[i*32 +: 32]};
  endfunction

  function automatic void vote(input int d, output bit ok, output int win);
    int nact;
    int votes;
    nact = 0;
    ok = 0;
    win = 0;
    for (int i = 0; i < nl(d); i++) if (!m_q[d][i]) nact++;
    for (int i = 0; i < nl(d); i++) begin
      if (ok || m_q[d][i]) continue;
      votes = 0;
      for (int j = 0; j < nl(d); j++)
        if (!m_q[d][j] && key(d, j) == key(d, i)) votes++;
      if (2 * votes > nact) begin
        ok = 1;
        win = i;
      end
    end
  endfunction

  function automatic logic [31:0] exp_word(input int d);
    bit ok; int win;
    logic [32:0] k;
    vote(d, ok, win);
    k = key(d, ok ? win : 0);
    return k[31:0];
  endfunction

  function automatic logic exp_we(input int d);
    bit ok; int win;
    logic [32:0] k;
    vote(d, ok, win);
    k = key(d, win);
    return ok && k[32] && (m_mode[d] == 0);
  endfunction

  function automatic logic [4:0] qmask(input int d);
    logic [4:0] r;
    r = '0;
    for (int i = 0; i < 5; i++) r[i] = m_q[d][i];
    return r;
  endfunction

  function automatic logic [4:0] mmask(input int d);
    logic [4:0] r;
    r = '0;
    for (int i = 0; i < 5; i++) r[i] = m_mm[d][i];
    return r;
  endfunction

  task automatic model_reset(input int d);
    m_mode[d] = 0;
    m_hold[d] = 0;
    for (int i = 0; i < 5; i++) begin
      m_cnt[d][i] = 0;
      m_q[d][i] = 0;
      m_mm[d][i] = 0;
    end
  endtask

  task automatic model_step(input int d);
    bit ok; int win; bit any;
    bit ack;
    ack = (d == 0) ? ack_a : ack_b;
    case (m_mode[d])
      0: begin
        vote(d, ok, win);
        any = 0;
        for (int i = 0; i < 5; i++) m_mm[d][i] = 0;
        if (!ok) m_mode[d] = 3;
        else begin
          for (int i = 0; i < nl(d); i++)
            if (!m_q[d][i] && key(d, i) != key(d, win)) begin
              m_mm[d][i] = 1;
              any = 1;
              if (m_cnt[d][i] < 7) m_cnt[d][i]++;
              if (m_cnt[d][i] >= 2) m_q[d][i] = 1;
            end
          if (any) begin
            m_mode[d] = 1;
            m_hold[d] = 2;
          end
        end
      end
      1: begin
        m_hold[d]--;
        if (m_hold[d] == 0) m_mode[d] = 2;
      end
      2: if (ack) m_mode[d] = 0;
      default: ;
    endcase
  endtask

  always @(posedge clk or negedge rst_a)
    if (!rst_a) model_reset(0); else model_step(0);
  always @(posedge clk or negedge rst_b)
    if (!rst_b) model_reset(1); else model_step(1);

  task automatic cmp(input int d);
    logic [31:0] w; logic we, h, r, f; logic [4:0] mm, q; logic [1:0] st;
    string s;
    s = (d == 0) ? "a" : "b";
    if (d == 0) begin
      w = vw_a; we = vwe_a; h = hold_a; r = req_a; f = fatal_a;
      mm = {2'b00, mm_a}; q = {2'b00, q_a}; st = st_a;
    end else begin
      w = vw_b; we = vwe_b; h = hold_b; r = req_b; f = fatal_b;
      mm = mm_b; q = q_b; st = st_b;
    end
    chk({s, ".voted_word"}, w, exp_word(d));
    chk({s, ".voted_we"}, we, exp_we(d));
    chk({s, ".core_hold"}, h, m_mode[d] != 0);
    chk({s, ".resync_req"}, r, m_mode[d] == 2);
    chk({s, ".fatal"}, f, m_mode[d] == 3);
    chk({s, ".vote_state"}, st, m_mode[d]);
    chk({s, ".lane_mismatch"}, mm, mmask(d));
    chk({s, ".lane_quarantine"}, q, qmask(d));
  endtask

  always @(negedge clk) begin
    cmp(0);
    cmp(1);
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_a = 1'b1; rst_b = 1'b1;
    word_a = {3{32'h0000_0013}}; we_a = '0; ack_a = 1'b0;
    word_b = {5{32'hA5A5_0000}}; we_b = '1; ack_b = 1'b0;
    #1 rst_a = 1'b0; rst_b = 1'b0;
    #2;
    chk("rst.core_hold", hold_a, 0);
    chk("rst.state", st_a, 0);
    chk("rst.quarantine", q_a, 0);
    chk("rst.voted_word", vw_a, 32'h13);
    chk("rst.voted_we_b", vwe_b, 1);
    step(1);
    rst_a = 1'b1; rst_b = 1'b1;

    step(3); #2;
    chk("a.steady.word", vw_a, 32'h13);
    chk("a.steady.hold", hold_a, 0);
    chk("a.steady.mm", mm_a, 0);
    chk("a.steady.fatal", fatal_a, 0);

    // first lane-1 fault and full hold/resync sequence
    word_a[63:32] = 32'hDEAD_BEEF; #2;
    chk("a.f1.vote", vw_a, 32'h13);
    step(1); word_a[63:32] = 32'h13; #2;
    chk("a.f1.mm", mm_a, 3'b010);
    chk("a.f1.hold", hold_a, 1);
    chk("a.f1.state", st_a, 1);
    chk("a.f1.quar", q_a, 0);
    step(1); #2;
    chk("a.f1.hold2", st_a, 1);
    step(1); #2;
    chk("a.f1.req", req_a, 1);
    chk("a.f1.resync", st_a, 2);
    step(2); #2;
    chk("a.f1.req3", req_a, 1);
    ack_a = 1'b1;
    step(1); ack_a = 1'b0; #2;
    chk("a.f1.run", st_a, 0);
    chk("a.f1.unhold", hold_a, 0);
    chk("a.f1.noreq", req_a, 0);

    // second fault quarantines lane 1; ack already high through HOLD
    word_a[63:32] = 32'h0BAD_0BAD; #2;
    chk("a.f2.vote", vw_a, 32'h13);
    step(1); word_a[63:32] = 32'h13; ack_a = 1'b1; #2;
    chk("a.f2.mm", mm_a, 3'b010);
    chk("a.f2.quar", q_a, 3'b010);
    chk("model.quar_a", qmask(0), 5'b00010);
    step(1); #2;
    chk("a.f2.ack_ignored", st_a, 1);
    step(1); #2;
    chk("a.f2.resync", st_a, 2);
    step(1); ack_a = 1'b0; #2;
    chk("a.f2.run", st_a, 0);
    word_a[63:32] = 32'hFFFF_FFFF;
    step(3); #2;
    chk("a.q.hold", hold_a, 0);
    chk("a.q.mm", mm_a, 0);
    chk("a.q.vote", vw_a, 32'h13);

    // two active lanes disagreeing on MemWrite -> FAIL
    we_a = 3'b001; #2;
    chk("a.nomaj.we", vwe_a, 0);
    chk("a.nomaj.word", vw_a, 32'h13);
    step(1); we_a = 3'b111; word_a[63:32] = 32'h13; #2;
    chk("a.fail.fatal", fatal_a, 1);
    chk("a.fail.hold", hold_a, 1);
    chk("a.fail.state", st_a, 3);
    chk("a.fail.we", vwe_a, 0);
    step(3); #2;
    chk("a.fail.sticky", st_a, 3);
    chk("a.fail.we2", vwe_a, 0);
    rst_a = 1'b0; #1;
    chk("a.rst.fatal", fatal_a, 0);
    chk("a.rst.state", st_a, 0);
    chk("a.rst.quar", q_a, 0);
    chk("a.rst.we", vwe_a, 1);
    step(1);
    rst_a = 1'b1;

    // three-way disagreement from RUN
    word_a = {32'h3, 32'h2, 32'h1}; we_a = '0; #2;
    chk("a.split.word", vw_a, 32'h1);
    step(1); #2;
    chk("a.split.fatal", fatal_a, 1);
    chk("a.split.quar", q_a, 0);
    chk("a.split.mm", mm_a, 0);
    rst_a = 1'b0;

    // 5-lane instance: lanes 3 and 4 wrong together, reset during RESYNC
    step(1);
    word_b[127:96] = 32'h1111; word_b[159:128] = 32'h2222; #2;
    chk("b.f.vote", vw_b, 32'hA5A5_0000);
    chk("b.f.we", vwe_b, 1);
    step(1); word_b = {5{32'hA5A5_0000}}; #2;
    chk("b.f.mm", mm_b, 5'b11000);
    chk("b.f.hold", hold_b, 1);
    chk("b.f.we_gated", vwe_b, 0);
    step(2); #2;
    chk("b.f.resync", st_b, 2);
    rst_b = 1'b0; #1;
    chk("b.rst.state", st_b, 0);
    chk("b.rst.hold", hold_b, 0);
    chk("b.rst.req", req_b, 0);
    chk("b.rst.mm", mm_b, 0);
    step(1);
    rst_b = 1'b1;

    for (int k = 0; k < 2; k++) begin
      word_b[127:96] = 32'h1111; word_b[159:128] = 32'h2222;
      step(1); word_b = {5{32'hA5A5_0000}}; ack_b = 1'b1;
      step(3); ack_b = 1'b0;
    end
    #2;
    chk("b.q.both", q_b, 5'b11000);
    chk("b.q.run", st_b, 0);
    chk("model.quar_b", qmask(1), 5'b11000);

    word_b[95:64] = 32'h7; #2;
    chk("b.l2.vote", vw_b, 32'hA5A5_0000);
    step(1); word_b[95:64] = 32'hA5A5_0000; ack_b = 1'b1; #2;
    chk("b.l2.mm", mm_b, 5'b00100);
    chk("b.l2.quar", q_b, 5'b11000);
    step(3); ack_b = 1'b0;
    word_b[159:96] = '1;
    step(2); #2;
    chk("b.ign.hold", hold_b, 0);
    chk("b.ign.mm", mm_b, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
